// File: rtl/msg_deframer_pkg.sv
// rtl/msg_deframer_pkg.sv - shared types for the AXI-Stream message deframer
package msg_deframer_pkg;

  localparam int MSG_DATA_BYTES_CAP = 32;

  typedef enum logic [2:0] {
    ST_CNT0,
    ST_CNT1,
    ST_LEN0,
    ST_LEN1,
    ST_PAY,
    ST_END,
    ST_DROP
  } parse_state_e;

  typedef struct packed {
    logic                              error;
    logic [15:0]                       length;
    logic [MSG_DATA_BYTES_CAP*8-1:0]   data;
  } msg_entry_t;

  // Bit positions in the per-beat error cause vector
  localparam int ERR_CNT_ZERO   = 0;
  localparam int ERR_LEN_RANGE  = 1;
  localparam int ERR_TUSER      = 2;
  localparam int ERR_TKEEP      = 3;
  localparam int ERR_EARLY_LAST = 4;
  localparam int ERR_TRAILING   = 5;
  localparam int ERR_NUM        = 6;

endpackage

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous FIFO with two write lanes per cycle and one read
module msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push0_i,
  input  logic [WIDTH-1:0]           data0_i,
  input  logic                       push1_i,
  input  logic [WIDTH-1:0]           data1_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wsel1;
  logic [AW:0]      count_q, count_d;
  logic             pop_en;

  always_comb begin
    pop_en  = pop_i && (count_q != '0);
    wsel1   = push0_i ? wptr_q + AW'(1) : wptr_q;
    wptr_d  = wptr_q + AW'(push0_i) + AW'(push1_i);
    rptr_d  = rptr_q + AW'(pop_en);
    count_d = count_q + (AW+1)'(push0_i) + (AW+1)'(push1_i) - (AW+1)'(pop_en);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed when the count is non-zero
  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wptr_q] <= data0_i;
    if (push1_i) mem_q[wsel1]  <= data1_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/axis_msg_deframer.sv
// rtl/axis_msg_deframer.sv - splits a counted, length-prefixed AXI-Stream packet into queued messages
module axis_msg_deframer
  import msg_deframer_pkg::*;
#(
  parameter int TDATA_BYTES   = 8,
  parameter int MIN_MSG_BYTES = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int OUT_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [TDATA_BYTES*8-1:0]   s_tdata,
  input  logic [TDATA_BYTES-1:0]     s_tkeep,
  input  logic                       s_tlast,
  input  logic                       s_tuser,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [15:0]                msg_length,
  output logic [MAX_MSG_BYTES*8-1:0] msg_data,
  output logic                       msg_error
);

  localparam int IW = (MAX_MSG_BYTES > 1) ? $clog2(MAX_MSG_BYTES) : 1;
  localparam int CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [15:0] MIN_LEN = 16'(MIN_MSG_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_BYTES);

  if (TDATA_BYTES > MIN_MSG_BYTES + 2) begin : g_chk_width
    $error("TDATA_BYTES must not exceed MIN_MSG_BYTES+2");
  end
  if (MAX_MSG_BYTES > MSG_DATA_BYTES_CAP || MIN_MSG_BYTES > MAX_MSG_BYTES) begin : g_chk_len
    $error("message length bounds out of range");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("OUT_DEPTH must be a power of two >= 2");
  end

  parse_state_e               state_q, state_d;
  logic [15:0]                cnt_q, cnt_d, len_q, len_d, idx_q, idx_d;
  logic [MAX_MSG_BYTES*8-1:0] pay_q, pay_d;

  logic                       beat, keep_contig;
  logic [TDATA_BYTES-1:0]     keep_inc;
  logic [7:0]                 b;
  logic [IW+2:0]              bit_off;
  logic                       good;
  logic [15:0]                good_len;
  logic [MAX_MSG_BYTES*8-1:0] good_data;
  logic [ERR_NUM-1:0]         err_vec;
  logic                       push_err;

  msg_entry_t                 good_entry, err_entry, fifo_data0, head;
  logic                       fifo_push0, fifo_push1, fifo_full, fifo_empty;
  logic [CW-1:0]              fifo_count;

  assign beat        = s_tvalid && s_tready;
  assign keep_inc    = s_tkeep + TDATA_BYTES'(1);
  assign keep_contig = ((keep_inc & s_tkeep) == '0);

  // Walk the beat byte by byte; a beat in error is not walked, so messages ending in it are dropped
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    pay_d     = pay_q;
    b         = '0;
    bit_off   = '0;
    good      = 1'b0;
    good_len  = '0;
    good_data = '0;
    err_vec   = '0;
    if (beat) begin
      if (state_q != ST_DROP && (s_tuser || !keep_contig)) begin
        err_vec[ERR_TUSER] = s_tuser;
        err_vec[ERR_TKEEP] = !keep_contig;
        state_d            = ST_DROP;
      end
      for (int i = 0; i < TDATA_BYTES; i++) begin
        b = s_tdata[8*i +: 8];
        if (s_tkeep[i] && !s_tuser && keep_contig) begin
          case (state_d)
            ST_CNT0: begin
              cnt_d[7:0] = b;
              state_d    = ST_CNT1;
            end
            ST_CNT1: begin
              cnt_d[15:8] = b;
              if (cnt_d == 16'd0) begin
                err_vec[ERR_CNT_ZERO] = 1'b1;
                state_d               = ST_DROP;
              end else begin
                state_d = ST_LEN0;
              end
            end
            ST_LEN0: begin
              len_d[7:0] = b;
              state_d    = ST_LEN1;
            end
            ST_LEN1: begin
              len_d[15:8] = b;
              if (len_d < MIN_LEN || len_d > MAX_LEN) begin
                err_vec[ERR_LEN_RANGE] = 1'b1;
                state_d                = ST_DROP;
              end else begin
                idx_d   = '0;
                pay_d   = '0;
                state_d = ST_PAY;
              end
            end
            ST_PAY: begin
              bit_off               = {idx_d[IW-1:0], 3'b000};
              pay_d[bit_off +: 8]   = b;
              idx_d                 = idx_d + 16'd1;
              if (idx_d == len_d) begin
                good      = 1'b1;
                good_len  = len_d;
                good_data = pay_d;
                cnt_d     = cnt_d - 16'd1;
                state_d   = (cnt_d == 16'd0) ? ST_END : ST_LEN0;
              end
            end
            ST_END: begin
              err_vec[ERR_TRAILING] = 1'b1;
              state_d               = ST_DROP;
            end
            default: ;
          endcase
        end
      end
      if (s_tlast) begin
        if (state_d != ST_END && state_d != ST_DROP) err_vec[ERR_EARLY_LAST] = 1'b1;
        state_d = ST_CNT0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CNT0;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
    end
  end

  // A good message always precedes the error in stream order, since an error ends parsing
  always_comb begin
    good_entry                           = '0;
    good_entry.length                    = good_len;
    good_entry.data[MAX_MSG_BYTES*8-1:0] = good_data;
    err_entry                            = '0;
    err_entry.error                      = 1'b1;
    push_err                             = |err_vec;
    fifo_push0                           = (good || push_err) && !fifo_full;
    fifo_push1                           = good && push_err && !fifo_full;
    fifo_data0                           = good ? good_entry : err_entry;
  end

  msg_fifo #(
    .WIDTH ($bits(msg_entry_t)),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push0_i (fifo_push0),
    .data0_i (fifo_data0),
    .push1_i (fifo_push1),
    .data1_i (err_entry),
    .pop_i   (msg_valid && msg_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Two free slots cover the worst-case double push while the registered count lags by a cycle
  assign s_tready   = !rst && (fifo_count <= CW'(OUT_DEPTH - 2));
  assign msg_valid  = !fifo_empty;
  assign msg_length = msg_valid ? head.length : '0;
  assign msg_error  = msg_valid ? head.error : 1'b0;
  assign msg_data   = msg_valid ? head.data[MAX_MSG_BYTES*8-1:0] : '0;

endmodule
